// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the converter FSM encoding and the shift-add-3 digit adjust constants.
package bcd_pkg;

    // Converter FSM: wait for a request, shift one bit per clock, present the result
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // A BCD digit at or above this value would overflow past 9 when doubled
    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;

    // Adding this before the shift makes the doubled digit carry into the next digit
    localparam logic [3:0] ADJ_VALUE = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit adjust stage for shift-add-3 conversion.
// Adds 3 to a BCD digit of 5 or more so that the following left shift
// produces a correct decimal carry. 4-bit result, no carry out.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Conditional +3 ahead of the doubling shift
    always_comb begin
        if (digit_in >= ADJ_THRESHOLD) begin
            digit_out = digit_in + ADJ_VALUE;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter feeding the hex_7seg digit drivers.
// Converts one IN_WIDTH-bit unsigned value per start request, one bit per clock,
// and holds the packed BCD result until the next conversion completes.
// Optional feature macro: BCD_LZ_BLANK_EN adds the blank_n leading-zero blanking output.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_LZ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_n
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

    state_t                    state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [IN_WIDTH-1:0]       shreg;
    logic [BCD_W-1:0]          scratch;
    logic [BCD_W-1:0]          adj_scratch;
    logic [BCD_W+IN_WIDTH-1:0] shifted;
    logic [BCD_W-1:0]          next_scratch;
    logic [IN_WIDTH-1:0]       next_shreg;

    // One adjust stage per digit, reused on every shift cycle
    for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch[4*g +: 4]),
            .digit_out (adj_scratch[4*g +: 4])
        );
    end

    // Adjusted scratch and remaining operand bits shift left together as one word
    assign shifted      = {adj_scratch, shreg} << 1;
    assign next_scratch = shifted[BCD_W+IN_WIDTH-1:IN_WIDTH];
    assign next_shreg   = shifted[IN_WIDTH-1:0];

`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] next_blank;
    logic              any_higher;

    // A digit stays lit if it or any more significant digit is nonzero; ones always lit
    always_comb begin
        next_blank = '0;
        any_higher = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_higher    = any_higher | (next_scratch[4*i +: 4] != 4'd0);
            next_blank[i] = any_higher;
        end
        next_blank[0] = 1'b1;
    end
`endif

    // Converter FSM, datapath and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            scratch <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
`ifdef BCD_LZ_BLANK_EN
            blank_n <= DIGITS'(1);
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= CONVERT;
                        shreg   <= bin_in;
                        scratch <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CONVERT: begin
                    shreg   <= next_shreg;
                    scratch <= next_scratch;
                    if (bit_cnt == LAST_CNT) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd_out <= next_scratch;
`ifdef BCD_LZ_BLANK_EN
                        blank_n <= next_blank;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter (default parameters).
// Define BCD_LZ_BLANK_EN for both bench and RTL to also check blank_n.
module tb_bcd_seq_converter;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
`ifdef BCD_LZ_BLANK_EN
    logic [2:0]  blank_n;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [2:0]  blank;
    } vec_t;

    vec_t vectors[12];

    bcd_seq_converter #(
        .IN_WIDTH (8),
        .DIGITS   (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out)
`ifdef BCD_LZ_BLANK_EN
        ,
        .blank_n  (blank_n)
`endif
    );

    // 50 MHz-style free-running clock
    always #5 CLOCK_50 = ~CLOCK_50;

    // Hard time limit so the bench can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue a one-cycle start; returns positioned in the first conversion cycle
    task automatic applyStimulus(input logic [7:0] value);
        start  = 1'b1;
        bin_in = value;
        step();
        start  = 1'b0;
        bin_in = 8'($urandom);
    endtask

    // Single conversion: timing, busy length, result and hold behaviour
    task automatic runVector(input vec_t v, input logic [11:0] prev);
        int          done_cycle;
        int          done_count;
        int          busy_cycles;
        logic        held_ok;
        logic [11:0] got;
        logic [2:0]  got_blank;
        done_cycle  = -1;
        done_count  = 0;
        busy_cycles = 0;
        held_ok     = 1'b1;
        got         = 12'hFFF;
        got_blank   = 3'b000;
        applyStimulus(v.bin);
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle = c;
                    got        = bcd_out;
`ifdef BCD_LZ_BLANK_EN
                    got_blank  = blank_n;
`endif
                end
            end
            if (done_cycle < 0 && bcd_out !== prev) held_ok = 1'b0;
            step();
        end
        checkOutput($sformatf("done_cycle[%0d]", v.bin), 32'(done_cycle), 32'd9);
        checkOutput($sformatf("done_count[%0d]", v.bin), 32'(done_count), 32'd1);
        checkOutput($sformatf("busy_cycles[%0d]", v.bin), 32'(busy_cycles), 32'd8);
        checkOutput($sformatf("bcd_at_done[%0d]", v.bin), 32'(got), 32'(v.bcd));
        checkOutput($sformatf("bcd_held_before[%0d]", v.bin), 32'(held_ok), 32'd1);
        checkOutput($sformatf("bcd_held_after[%0d]", v.bin), 32'(bcd_out), 32'(v.bcd));
`ifdef BCD_LZ_BLANK_EN
        checkOutput($sformatf("blank_n[%0d]", v.bin), 32'(got_blank), 32'(v.blank));
`else
        got_blank = v.blank;
`endif
    endtask

    initial begin
        int          dc;
        int          cnt;
        int          busy_seen;
        logic [11:0] got;
        logic [11:0] last;

        vectors[0]  = '{8'd0,   12'h000, 3'b001};
        vectors[1]  = '{8'd126, 12'h126, 3'b111};
        vectors[2]  = '{8'd255, 12'h255, 3'b111};
        vectors[3]  = '{8'd99,  12'h099, 3'b011};
        vectors[4]  = '{8'd7,   12'h007, 3'b001};
        vectors[5]  = '{8'd105, 12'h105, 3'b111};
        vectors[6]  = '{8'd0,   12'h000, 3'b001};
        vectors[7]  = '{8'd10,  12'h010, 3'b011};
        vectors[8]  = '{8'd200, 12'h200, 3'b111};
        vectors[9]  = '{8'd1,   12'h001, 3'b001};
        vectors[10] = '{8'd50,  12'h050, 3'b011};
        vectors[11] = '{8'd180, 12'h180, 3'b111};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'd0);
`ifdef BCD_LZ_BLANK_EN
        checkOutput("reset_blank_n", 32'(blank_n), 32'b001);
`endif
        step();

        // Table-driven single conversions
        last = 12'h000;
        for (int i = 0; i < 12; i++) begin
            runVector(vectors[i], last);
            last = vectors[i].bcd;
        end

        // Start held high: back-to-back conversions, done every 9 cycles
        start  = 1'b1;
        bin_in = 8'd10;
        step();
        bin_in = 8'd200;
        for (int c = 1; c <= 18; c++) begin
            checkOutput($sformatf("b2b_done_c%0d", c), 32'(done), 32'((c == 9) || (c == 18)));
            checkOutput($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'(!((c == 9) || (c == 18))));
            if (c == 9)  checkOutput("b2b_bcd_first", 32'(bcd_out), 32'h010);
            if (c == 18) begin
                checkOutput("b2b_bcd_second", 32'(bcd_out), 32'h200);
                start = 1'b0;
            end
            step();
        end
        checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
        step();

        // Start pulsed mid-conversion must be ignored
        applyStimulus(8'd37);
        dc  = -1;
        cnt = 0;
        got = 12'hFFF;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                cnt++;
                if (dc < 0) begin
                    dc  = c;
                    got = bcd_out;
                end
            end
            if (c == 3) begin
                start  = 1'b1;
                bin_in = 8'd64;
            end else if (c == 4) begin
                start  = 1'b0;
                bin_in = 8'($urandom);
            end
            step();
        end
        checkOutput("ignore_done_cycle", 32'(dc), 32'd9);
        checkOutput("ignore_done_count", 32'(cnt), 32'd1);
        checkOutput("ignore_bcd_at_done", 32'(got), 32'h037);
        checkOutput("ignore_bcd_final", 32'(bcd_out), 32'h037);

        // Reset in the middle of a conversion aborts it
        applyStimulus(8'd180);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_bcd", 32'(bcd_out), 32'h000);
`ifdef BCD_LZ_BLANK_EN
        checkOutput("abort_blank_n", 32'(blank_n), 32'b001);
`endif
        cnt       = 0;
        busy_seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) cnt++;
            if (busy) busy_seen++;
            step();
        end
        checkOutput("abort_no_done", 32'(cnt), 32'd0);
        checkOutput("abort_no_busy", 32'(busy_seen), 32'd0);
        checkOutput("abort_bcd_held", 32'(bcd_out), 32'h000);

        // Recovery after the aborted conversion
        runVector('{8'd42, 12'h042, 3'b011}, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
